writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Registered RV32/RV64 writeback stage. Accepts one retiring instruction per handshake from the memory stage.
//  Waits for variable-latency data-memory load responses, then sign/zero-extends and aligns the load data.
//  Selects the ALU / load / PC+PC_INC / CSR source and drives the register-file write port one cycle later.
//  Stalls upstream while a load response is outstanding; a timeout counter flags a lost response.
// PARAMETERS
//  XLEN          32   datapath width; legal values 32, 64
//  REG_ADDR_W    5    register index width
//  PC_INC        4    increment added to pc for the link source
//  TIMEOUT_CYC   64   max cycles in WAIT_LOAD before timeout; >=2
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous active-low reset
//  in_valid       in   1           upstream instruction valid
//  in_ready       out  1           stage can accept (combinational from state)
//  in_wb_sel      in   2           wb_pkg::wb_sel_e source select
//  in_rf_we       in   1           instruction writes rd
//  in_rd          in   REG_ADDR_W  destination register
//  in_is_load     in   1           instruction is a load (response pending)
//  in_funct3      in   3           load size/sign encoding
//  in_alu_result  in   XLEN        ALU result; low bits = load byte address
//  in_pc          in   XLEN        instruction PC
//  in_csr_rdata   in   XLEN        CSR read data
//  dmem_rvalid    in   1           load response valid (single-cycle pulse)
//  dmem_rdata     in   XLEN        load response data, naturally aligned word/dword
//  rf_we          out  1           register-file write enable (registered)
//  rf_waddr       out  REG_ADDR_W  register-file write index
//  rf_wdata       out  XLEN        register-file write data
//  err_unexp_rsp  out  1           sticky: dmem_rvalid seen outside WAIT_LOAD
//  err_timeout    out  1           sticky: load response not received within TIMEOUT_CYC
// BEHAVIOUR
//  Reset: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, err_*=0, timeout counter=0.
//  FSM states are IDLE and WAIT_LOAD. in_ready=1 only in IDLE. Accept = in_valid && in_ready.
//  IDLE, accept with in_is_load=0: next cycle rf_we=in_rf_we && (in_rd!=0), rf_wdata=mux(in_wb_sel). Stays IDLE. Latency 1.
//  IDLE, accept with in_is_load=1: capture rd, rf_we, funct3, addr low bits. Go to WAIT_LOAD with counter=0.
//   No rf write is issued for the load in the acceptance cycle.
//  WAIT_LOAD: counter increments each cycle.
//   On dmem_rvalid: next cycle rf_we=captured_we && rd!=0, rf_wdata=formatted load data. Go to IDLE.
//   If counter reaches TIMEOUT_CYC-1 without rvalid: set err_timeout, suppress the write, go to IDLE.
//   rvalid arriving in that same cycle wins: the write is issued and no error is raised.
//  Mux by wb_sel_e: ALU=in_alu_result, MEM=formatted load, PC4=in_pc+PC_INC (mod 2^XLEN), CSR=in_csr_rdata.
//   in_wb_sel!=MEM with in_is_load=1 still waits for the response, then writes the selected non-MEM value.
//  Load format: byte offset=addr[$clog2(XLEN/8)-1:0].
//   LB/LBU extract 8 bits; LH/LHU extract 16 bits at offset[..:1]*2; LW/LWU extract 32 bits (XLEN=64).
//   LB/LH/LW sign-extend; BU/HU/WU zero-extend; LD (XLEN=64) or LW (XLEN=32) passes full data.
//   Unsupported funct3 passes dmem_rdata unchanged. Misaligned offsets are truncated, never trapped.
//  dmem_rvalid in IDLE (including the acceptance cycle) is ignored for data and sets err_unexp_rsp.
//  rf_we is a one-cycle pulse. rf_waddr/rf_wdata hold their values when rf_we=0.
//  rst_n assertion mid-WAIT_LOAD aborts the load. A later response is then flagged as err_unexp_rsp.
// CONFIGURATION
//  WB_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd(REG_ADDR_W), fwd_data(XLEN).
//   Driven combinationally with the value to be written next cycle (bypass to execute).
//   fwd_valid=0 while WAIT_LOAD has no response yet.
//  WB_FWD_EN undefined: these ports and their logic do not exist. Core relies on the registered rf port only.
// STRUCTURE
//  wb_pkg: wb_sel_e {WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_CSR=3}; wb_state_e {IDLE, WAIT_LOAD};
//   LOAD_F3_* funct3 constants (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110).
//  Sub-module load_formatter: combinational (dmem_rdata, offset, funct3) -> formatted XLEN data. Parametrised by XLEN.
// TESTING
//  ALU write: in_wb_sel=ALU, rd=5, alu=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x00001234.
//  x0 suppression: rd=0, in_rf_we=1 -> rf_we stays 0.
//  LB sign: addr=0x...3, rdata=0x80FFFFFF, rvalid 3 cycles later -> in_ready=0 for 3 cycles, then wdata=0xFFFFFF80.
//  LHU: addr low=2, rdata=0xBEEF1234 -> wdata=0x0000BEEF. PC4: pc=0xFFFFFFFC -> wdata=0x00000000.
//  Timeout: load accepted, no rvalid for TIMEOUT_CYC cycles -> err_timeout=1, rf_we=0, in_ready=1 again.
//  Unexpected rsp: rvalid in IDLE -> err_unexp_rsp=1. rst_n low mid-WAIT_LOAD -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
//   wb_sel_e    register-file write source select
//   wb_state_e  writeback FSM states
//   LOAD_F3_*   load funct3 encodings (size / signedness)
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LD  = 3'b011;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;
  localparam logic [2:0] LOAD_F3_LWU = 3'b110;

endpackage

// File: rtl/load_formatter.sv
// load_formatter: aligns and sign/zero-extends raw load response data.
// Purely combinational.
// Ports:
//   i_rdata   naturally aligned word/dword from data memory
//   i_offset  byte offset of the access inside that word/dword
//   i_funct3  load size/sign encoding (LOAD_F3_*)
//   o_data    formatted register-file value
// Misaligned offsets are truncated to the access size; unknown funct3 passes i_rdata.
module load_formatter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  i_rdata,
  input  logic [2:0]       i_funct3,
  input  logic [OFF_W-1:0] i_offset,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_byte_sh;
  logic [XLEN-1:0] w_half_sh;
  logic [XLEN-1:0] w_word_sh;
  logic            w_word_hi;

  // Only a 64-bit datapath has two words to choose from. With XLEN=32 the word
  // path degenerates to the full data, which is also what LD/LWU must return there.
  assign w_word_hi = (XLEN == 64) && i_offset[OFF_W-1];

  assign w_byte_sh = i_rdata >> {i_offset, 3'b000};
  assign w_half_sh = i_rdata >> {i_offset[OFF_W-1:1], 4'b0000};
  assign w_word_sh = i_rdata >> {w_word_hi, 5'b00000};

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      LOAD_F3_LB:  o_data = XLEN'($signed(w_byte_sh[7:0]));
      LOAD_F3_LH:  o_data = XLEN'($signed(w_half_sh[15:0]));
      LOAD_F3_LW:  o_data = XLEN'($signed(w_word_sh[31:0]));
      LOAD_F3_LBU: o_data = XLEN'(w_byte_sh[7:0]);
      LOAD_F3_LHU: o_data = XLEN'(w_half_sh[15:0]);
      LOAD_F3_LWU: o_data = XLEN'(w_word_sh[31:0]);
      LOAD_F3_LD:  o_data = i_rdata;
      default:     o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registered RV32/RV64 writeback stage.
// Accepts one retiring instruction per handshake, waits for a variable-latency
// load response when needed, and drives the register-file write port one cycle later.
// Optional feature macro: WB_FWD_EN adds a combinational bypass (fwd_*) of the
// value that the register file will receive on the next clock edge.
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   in_valid / in_ready          upstream handshake; ready only in IDLE
//   in_wb_sel, in_rf_we, in_rd   write source, write enable, destination
//   in_is_load, in_funct3        load marker and size/sign encoding
//   in_alu_result, in_pc         ALU result (also load address), instruction PC
//   in_csr_rdata                 CSR read data
//   dmem_rvalid, dmem_rdata      load response pulse and data
//   rf_we, rf_waddr, rf_wdata    registered register-file write port
//   fwd_valid, fwd_rd, fwd_data  bypass of next-cycle write (WB_FWD_EN only)
//   err_unexp_rsp, err_timeout   sticky error flags
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned PC_INC      = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  wb_sel_e               in_wb_sel,
  input  logic                  in_rf_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_csr_rdata,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
`endif
  output logic                  err_unexp_rsp,
  output logic                  err_timeout
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  // FSM and load context
  wb_state_e             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [REG_ADDR_W-1:0] r_ld_rd;
  logic                  r_ld_we;
  logic [2:0]            r_ld_f3;
  logic [OFF_W-1:0]      r_ld_off;
  wb_sel_e               r_ld_sel;
  logic [XLEN-1:0]       r_ld_alt;

  // Registered outputs
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_err_unexp;
  logic                  r_err_timeout;

  logic                  w_accept;
  logic                  w_wr_fire;
  logic                  w_timeout;
  logic [REG_ADDR_W-1:0] w_wr_addr;
  logic [XLEN-1:0]       w_wr_data;
  logic [XLEN-1:0]       w_sel_val;
  logic [XLEN-1:0]       w_fmt_data;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;

  load_formatter #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_formatter (
    .i_rdata  (dmem_rdata),
    .i_funct3 (r_ld_f3),
    .i_offset (r_ld_off),
    .o_data   (w_fmt_data)
  );

  // Non-load source value of the incoming instruction. A load whose select is
  // not MEM stores this at acceptance and writes it once the response arrives.
  always_comb begin
    w_sel_val = in_alu_result;
    unique case (in_wb_sel)
      WB_ALU: w_sel_val = in_alu_result;
      WB_PC4: w_sel_val = in_pc + XLEN'(PC_INC);
      WB_CSR: w_sel_val = in_csr_rdata;
      // A non-load has no response to format; fall back to the ALU value.
      WB_MEM: w_sel_val = in_alu_result;
    endcase
  end

  // Decode what the register file receives on the next edge.
  always_comb begin
    w_wr_fire = 1'b0;
    w_wr_addr = in_rd;
    w_wr_data = w_sel_val;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wr_fire = w_accept && !in_is_load && in_rf_we && (in_rd != '0);
      end
      WAIT_LOAD: begin
        w_wr_addr = r_ld_rd;
        w_wr_data = (r_ld_sel == WB_MEM) ? w_fmt_data : r_ld_alt;
        // A response in the final counted cycle still wins over the timeout.
        if (dmem_rvalid) begin
          w_wr_fire = r_ld_we;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_timeout = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ld_rd       <= '0;
      r_ld_we       <= 1'b0;
      r_ld_f3       <= '0;
      r_ld_off      <= '0;
      r_ld_sel      <= WB_ALU;
      r_ld_alt      <= '0;
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_err_unexp   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rf_we <= w_wr_fire;
      // Address and data only move with a write, so they hold between pulses.
      if (w_wr_fire) begin
        r_rf_waddr <= w_wr_addr;
        r_rf_wdata <= w_wr_data;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (dmem_rvalid && (r_state == IDLE)) begin
        r_err_unexp <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_accept && in_is_load) begin
            r_state  <= WAIT_LOAD;
            r_cnt    <= '0;
            r_ld_rd  <= in_rd;
            r_ld_we  <= in_rf_we && (in_rd != '0);
            r_ld_f3  <= in_funct3;
            r_ld_off <= in_alu_result[OFF_W-1:0];
            r_ld_sel <= in_wb_sel;
            r_ld_alt <= w_sel_val;
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid || w_timeout) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign rf_we         = r_rf_we;
  assign rf_waddr      = r_rf_waddr;
  assign rf_wdata      = r_rf_wdata;
  assign err_unexp_rsp = r_err_unexp;
  assign err_timeout   = r_err_timeout;

`ifdef WB_FWD_EN
  assign fwd_valid = w_wr_fire;
  assign fwd_rd    = w_wr_addr;
  assign fwd_data  = w_wr_data;
`endif

endmodule
